// File: rtl/bus_trace_checker.sv
// Hardware expectation table that checks a live CPU bus against stamped events.
// Optional CHECK_HALT_ON_FAIL_EN: stop at the first mismatch or timeout.
module bus_trace_checker #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_rw,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [CNT_W-1:0]  ld_cycle,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_rw,
  input  logic [2:0]        ld_mask,
  input  logic              arm,
  output logic [CNT_W-1:0]  cycle,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic              order_err,
  output logic [PW-1:0]     fail_index,
  output logic [CNT_W-1:0]  fail_cycle
);

`ifdef CHECK_HALT_ON_FAIL_EN
  typedef enum logic [1:0] {
    S_LOAD, S_RUN, S_DONE, S_HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_LOAD, S_RUN, S_DONE
  } state_t;
`endif

  state_t            state_q;
  logic [PW:0]       cnt_q;
  logic [PW:0]       cnt_d;
  logic [PW:0]       rp_q;
  logic [CNT_W-1:0]  last_q;
  logic [CNT_W-1:0]  cycle_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [7:0]        err_q;
  logic [7:0]        err_d;
  logic              oerr_q;
  logic [PW-1:0]     fidx_q;
  logic [CNT_W-1:0]  fcyc_q;

  logic [CNT_W-1:0]  t_cyc  [DEPTH];
  logic [ADDR_W-1:0] t_addr [DEPTH];
  logic [DATA_W-1:0] t_data [DEPTH];
  logic              t_rw   [DEPTH];
  logic [2:0]        t_mask [DEPTH];

  logic [PW-1:0] rp_idx;
  logic [2:0]    m;
  logic          ld_acc;
  logic          ld_ok;
  logic          ld_wr;
  logic          hit;
  logic          miss;
  logic          tmo;
  logic          fail;
  logic          last_ent;

  always_comb begin
    rp_idx   = rp_q[PW-1:0];
    m        = t_mask[rp_idx];
    ld_ready = (state_q == S_LOAD) &&
               (cnt_q != (PW+1)'(DEPTH));
    ld_acc   = ld_valid && ld_ready;
    ld_ok    = (cnt_q == '0) || (ld_cycle > last_q);
    ld_wr    = ld_acc && ld_ok;
    cnt_d    = cnt_q + (PW+1)'(ld_wr);
    hit      = (state_q == S_RUN) &&
               (cycle_q == t_cyc[rp_idx]);
    miss     = hit && (
                 (m[0] && bus_addr != t_addr[rp_idx]) ||
                 (m[1] && bus_data != t_data[rp_idx]) ||
                 (m[2] && bus_rw   != t_rw[rp_idx]));
    // Counter exhausted while entries still wait.
    tmo      = (state_q == S_RUN) && !hit &&
               (cycle_q == '1);
    fail     = miss || tmo;
    err_d    = (fail && err_q != 8'hFF) ?
               err_q + 8'd1 : err_q;
    last_ent = (rp_q + (PW+1)'(1)) == cnt_q;
  end

  always_ff @(posedge clk) begin
    if (ld_wr) begin
      t_cyc[cnt_q[PW-1:0]]  <= ld_cycle;
      t_addr[cnt_q[PW-1:0]] <= ld_addr;
      t_data[cnt_q[PW-1:0]] <= ld_data;
      t_rw[cnt_q[PW-1:0]]   <= ld_rw;
      t_mask[cnt_q[PW-1:0]] <= ld_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      rp_q    <= '0;
      last_q  <= '0;
      cycle_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      oerr_q  <= 1'b0;
      fidx_q  <= '0;
      fcyc_q  <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          cnt_q <= cnt_d;
          if (ld_wr)
            last_q <= ld_cycle;
          if (ld_acc && !ld_ok)
            oerr_q <= 1'b1;
          if (arm) begin
            cycle_q <= '0;
            rp_q    <= '0;
            if (cnt_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!tmo)
            cycle_q <= cycle_q + CNT_W'(1);
          if (hit)
            rp_q <= rp_q + (PW+1)'(1);
          err_q <= err_d;
          if (fail && err_q == '0) begin
            fidx_q <= rp_idx;
            fcyc_q <= cycle_q;
          end
`ifdef CHECK_HALT_ON_FAIL_EN
          if (fail) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
          end else if (hit && last_ent) begin
`else
          if (tmo || (hit && last_ent)) begin
`endif
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        S_DONE: ;
`ifdef CHECK_HALT_ON_FAIL_EN
        S_HALT: ;
`endif
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign cycle      = cycle_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign order_err  = oerr_q;
  assign fail_index = fidx_q;
  assign fail_cycle = fcyc_q;

endmodule

// File: tb/tb_bus_trace_checker.sv
// Directed bench for bus_trace_checker with hand-computed results.
// Honours CHECK_HALT_ON_FAIL_EN for the two-mismatch case.
module tb_bus_trace_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_rw;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_cycle;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_rw;
  logic [2:0]  ld_mask;
  logic        arm;
  logic [15:0] cycle;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic        order_err;
  logic [3:0]  fail_index;
  logic [15:0] fail_cycle;

  bus_trace_checker dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_rw(bus_rw), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_cycle(ld_cycle),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_rw(ld_rw), .ld_mask(ld_mask), .arm(arm),
    .cycle(cycle), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
    .order_err(order_err), .fail_index(fail_index),
    .fail_cycle(fail_cycle)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] sc_cyc  [16];
  logic [15:0] sc_addr [16];
  logic [7:0]  sc_data [16];
  logic        sc_rw   [16];
  int          n_sc;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    arm = 1'b0;
    ld_valid = 1'b0;
    n_sc = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load(input logic [15:0] c,
                      input logic [15:0] a,
                      input logic [7:0]  d,
                      input logic        r,
                      input logic [2:0]  mk);
    ld_valid = 1'b1;
    ld_cycle = c;
    ld_addr  = a;
    ld_data  = d;
    ld_rw    = r;
    ld_mask  = mk;
    @(posedge clk);
    #1 ld_valid = 1'b0;
  endtask

  task automatic add_sc(input logic [15:0] c,
                        input logic [15:0] a,
                        input logic [7:0]  d,
                        input logic        r);
    sc_cyc[n_sc]  = c;
    sc_addr[n_sc] = a;
    sc_data[n_sc] = d;
    sc_rw[n_sc]   = r;
    n_sc++;
  endtask

  task automatic drive_bus();
    bus_addr = 16'hFFFF;
    bus_data = 8'hFF;
    bus_rw   = 1'b0;
    for (int i = 0; i < n_sc; i++)
      if (cycle == sc_cyc[i]) begin
        bus_addr = sc_addr[i];
        bus_data = sc_data[i];
        bus_rw   = sc_rw[i];
      end
  endtask

  task automatic run(input int budget,
                     input logic exp_busy);
    int k;
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    ld_valid = 1'b0;
    check("busy_after_arm", busy, exp_busy);
    k = 0;
    while (!done && k < budget) begin
      drive_bus();
      @(posedge clk);
      #1;
      k++;
    end
    if (!done)
      check("run_budget", done, 1);
  endtask

  initial begin
    bus_addr = '0; bus_data = '0; bus_rw = 1'b0;
    ld_cycle = '0; ld_addr = '0; ld_data = '0;
    ld_rw = 1'b0; ld_mask = '0;
    do_reset();
    check("rst_ready", ld_ready, 1);
    check("rst_cycle", cycle, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_oerr", order_err, 0);
    check("rst_fidx", fail_index, 0);
    check("rst_fcyc", fail_cycle, 0);

    // Matching full-mask entry
    do_reset();
    load(16'h0027, 16'h0099, 8'h84, 1'b0, 3'b111);
    add_sc(16'h0027, 16'h0099, 8'h84, 1'b0);
    run(100, 1'b1);
    check("t1_done", done, 1);
    check("t1_cycle", cycle, 16'h0028);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_busy", busy, 0);

    // Data mismatch
    do_reset();
    load(16'h0027, 16'h0099, 8'h84, 1'b0, 3'b111);
    add_sc(16'h0027, 16'h0099, 8'h04, 1'b0);
    run(100, 1'b1);
    check("t2_err", err_count, 1);
    check("t2_fidx", fail_index, 0);
    check("t2_fcyc", fail_cycle, 16'h0027);
    check("t2_pass", pass, 0);
    check("t2_done", done, 1);

    // Address-only mask ignores data and rw
    do_reset();
    load(16'h0008, 16'h1234, 8'h55, 1'b1, 3'b001);
    add_sc(16'h0008, 16'h1234, 8'hAA, 1'b0);
    run(50, 1'b1);
    check("t3_pass", pass, 1);
    check("t3_cycle", cycle, 16'h0009);

    // Non-ascending stamp is dropped
    do_reset();
    load(16'h0010, 16'h0300, 8'h11, 1'b1, 3'b111);
    load(16'h0010, 16'h0400, 8'h22, 1'b0, 3'b111);
    check("t4_oerr", order_err, 1);
    add_sc(16'h0010, 16'h0300, 8'h11, 1'b1);
    run(50, 1'b1);
    check("t4_err", err_count, 0);
    check("t4_pass", pass, 1);
    check("t4_cycle", cycle, 16'h0011);
    check("t4_oerr_hold", order_err, 1);

    // Full table, mismatches at 0x05 and 0x09
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check("t5_ready_pre", ld_ready, 1);
      load(16'(i + 1), 16'h0200 + 16'(i),
           8'(i), 1'b1, 3'b111);
      add_sc(16'(i + 1), 16'h0200 + 16'(i),
             (i == 4 || i == 8) ? 8'(i) ^ 8'h01
                                : 8'(i), 1'b1);
    end
    check("t5_full_ready", ld_ready, 0);
    ld_valid = 1'b1;
    ld_cycle = 16'h0040;
    @(posedge clk);
    #1 ld_valid = 1'b0;
    check("t5_extra_oerr", order_err, 0);
    check("t5_extra_ready", ld_ready, 0);
    run(100, 1'b1);
    check("t5_done", done, 1);
    check("t5_pass", pass, 0);
    check("t5_fidx", fail_index, 4);
    check("t5_fcyc", fail_cycle, 16'h0005);
`ifdef CHECK_HALT_ON_FAIL_EN
    check("t5_err", err_count, 1);
    check("t5_cycle", cycle, 16'h0006);
    repeat (3) @(posedge clk);
    #1;
    check("t5_frozen", cycle, 16'h0006);
    check("t5_err_hold", err_count, 1);
`else
    check("t5_err", err_count, 2);
    check("t5_cycle", cycle, 16'h0011);
`endif

    // Load and arm on the same cycle
    do_reset();
    ld_valid = 1'b1;
    ld_cycle = 16'h0003;
    ld_addr  = 16'h0040;
    ld_data  = 8'h7E;
    ld_rw    = 1'b1;
    ld_mask  = 3'b111;
    add_sc(16'h0003, 16'h0040, 8'h7E, 1'b1);
    run(20, 1'b1);
    check("t6_pass", pass, 1);
    check("t6_cycle", cycle, 16'h0004);
    check("t6_err", err_count, 0);

    // Empty table
    do_reset();
    run(5, 1'b0);
    check("t7_done", done, 1);
    check("t7_pass", pass, 1);
    check("t7_err", err_count, 0);

    // Reset mid-run
    do_reset();
    load(16'h0030, 16'h0500, 8'h01, 1'b0, 3'b111);
    arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    for (int k = 0; k < 50 && cycle != 16'h000C; k++) begin
      @(posedge clk);
      #1;
    end
    check("t8_pre_cycle", cycle, 16'h000C);
    check("t8_pre_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t8_cycle", cycle, 0);
    check("t8_busy", busy, 0);
    check("t8_done", done, 0);
    check("t8_pass", pass, 0);
    check("t8_err", err_count, 0);
    check("t8_ready", ld_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t8_idle", cycle, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
